cla_adder_pipe: RTL and testbench



---
 rtl/cla_pkg.sv | 30 +++
 rtl/cla_group.sv | 65 ++++++
 rtl/cla_adder_pipe.sv | 175 +++++++++++++++++
 tb/tb_cla_adder_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cla_pkg
//  Description : Shared constants, types and helpers for the pipelined
//                carry-lookahead adder (cla_adder_pipe / cla_group).
//  Revision    : 1.0 - initial release
// ============================================================================
package cla_pkg;

  // Bits per lookahead group when the instantiator does not override BLOCK.
  localparam int CLA_DEFAULT_BLOCK = 4;

  // Control payload carried by every inter-stage pipeline register.
  // Operand skew and partial-sum fields differ in width from stage to stage
  // (operands shrink and the partial sum grows by BLOCK bits per stage), so
  // they sit beside this struct in the stage register rather than inside it.
  typedef struct packed {
    logic valid;  // a real operation (not a bubble) occupies this stage
    logic carry;  // carry out of the group just resolved
  } cla_ctl_t;

  // Number of lookahead groups, which is also the pipeline depth.
  // A degenerate BLOCK is mapped to 1 so elaboration can reach the
  // parameter check and report it instead of dividing by zero.
  function automatic int cla_ngrp(input int width, input int block);
    return (block < 1) ? 1 : (width / block);
  endfunction

endpackage : cla_pkg
`default_nettype wire

// File: rtl/cla_group.sv
`default_nettype none
// ============================================================================
//  Module      : cla_group
//  Description : BLOCK-bit combinational carry-lookahead group. Every internal
//                carry is produced from a flat sum-of-products expansion of
//                the bit generate/propagate terms, never by rippling.
//                Group generate (gg) and group propagate (gp) are exported
//                for lookahead across group boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_group
  import cla_pkg::*;
#(
  parameter int BLOCK = CLA_DEFAULT_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             gp,
  output logic             gg
);

  logic [BLOCK-1:0] w_g;  // bit generate
  logic [BLOCK-1:0] w_p;  // bit propagate
  logic [BLOCK:0]   w_c;  // carry into bit i (w_c[BLOCK] is the group carry out)

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Carry into bit n, expanded as:
  //   c[n] = OR_j ( g[j] & p[j+1] & ... & p[n-1] )  |  ( p[0] & ... & p[n-1] & c0 )
  // The loops unroll at elaboration into a two-level AND/OR network.
  function automatic logic f_carry(input logic [BLOCK-1:0] gv,
                                   input logic [BLOCK-1:0] pv,
                                   input logic             c0,
                                   input int               n);
    logic acc;
    logic term;
    acc = c0;
    for (int k = 0; k < n; k++) begin
      acc = acc & pv[k];
    end
    for (int j = 0; j < n; j++) begin
      term = gv[j];
      for (int k = j + 1; k < n; k++) begin
        term = term & pv[k];
      end
      acc = acc | term;
    end
    return acc;
  endfunction

  for (genvar i = 0; i <= BLOCK; i++) begin : g_carry
    assign w_c[i] = f_carry(w_g, w_p, ci, i);
  end

  assign s  = w_p ^ w_c[BLOCK-1:0];
  assign co = w_c[BLOCK];
  assign gp = &w_p;
  assign gg = f_carry(w_g, w_p, 1'b0, BLOCK);

endmodule : cla_group
`default_nettype wire

// File: rtl/cla_adder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : cla_adder_pipe
//  Description : Parametrised pipelined carry-lookahead adder.
//                sum/cout = a + b + cin (unsigned, modulo 2^WIDTH).
//                The operand is cut into NGRP = WIDTH/BLOCK lookahead groups;
//                group g is resolved in pipeline stage g using the carry
//                registered by stage g-1. Operand slices of higher groups
//                travel alongside (input skew) and resolved low sum slices
//                accumulate alongside (output deskew), so every result bit
//                leaves the pipe together, NGRP cycles after acceptance.
//                Valid/ready on both sides; the whole pipe freezes while a
//                finished result waits for the consumer.
//  Options     : `define CLA_OVERFLOW_EN adds output ovf, the two's-complement
//                overflow flag, registered alongside sum/cout.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = CLA_DEFAULT_BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NGRP = cla_ngrp(WIDTH, BLOCK);

  if (BLOCK < 1) begin : g_err_block
    $error("cla_adder_pipe: BLOCK (%0d) must be at least 1", BLOCK);
  end else if ((WIDTH % BLOCK) != 0) begin : g_err_width
    $error("cla_adder_pipe: WIDTH (%0d) must be a multiple of BLOCK (%0d)",
           WIDTH, BLOCK);
  end

  // --------------------------------------------------------------------------
  // Flow control: a finished result the consumer refuses freezes every stage.
  // Bubbles are never squeezed out, so result order equals acceptance order.
  // --------------------------------------------------------------------------
  logic             w_stall;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  assign w_stall   = r_out_valid & ~out_ready;
  assign in_ready  = ~w_stall;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;

`ifdef CLA_OVERFLOW_EN
  logic r_ovf;
  assign ovf = r_ovf;
`endif

  // --------------------------------------------------------------------------
  // One generate iteration per lookahead group / pipeline stage.
  // Stage g sees the operand bits still unresolved ([WIDTH-1 : g*BLOCK]),
  // consumes its low BLOCK bits and forwards the rest one stage further.
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    localparam int LO = g * BLOCK;

    logic [WIDTH-LO-1:0] w_a_in;   // unresolved operand A bits, group g at LSB
    logic [WIDTH-LO-1:0] w_b_in;   // unresolved operand B bits, group g at LSB
    logic                w_ci;     // carry into group g
    logic                w_vin;    // stage occupancy arriving at group g
    logic [LO+BLOCK-1:0] w_ps;     // sum bits resolved through group g
    logic [BLOCK-1:0]    w_s;
    logic                w_co;
    logic                w_gp;
    logic                w_gg;
    logic                w_cy;     // carry handed to the next group

    if (g == 0) begin : g_src_port
      assign w_a_in = a;
      assign w_b_in = b;
      assign w_ci   = cin;
      assign w_vin  = in_valid;
      assign w_ps   = w_s;
    end else begin : g_src_stage
      assign w_a_in = g_grp[g-1].g_reg.r_a;
      assign w_b_in = g_grp[g-1].g_reg.r_b;
      assign w_ci   = g_grp[g-1].g_reg.r_ctl.carry;
      assign w_vin  = g_grp[g-1].g_reg.r_ctl.valid;
      assign w_ps   = {w_s, g_grp[g-1].g_reg.r_ps};
    end

    cla_group #(
      .BLOCK (BLOCK)
    ) u_cla_group (
      .a  (w_a_in[BLOCK-1:0]),
      .b  (w_b_in[BLOCK-1:0]),
      .ci (w_ci),
      .s  (w_s),
      .co (w_co),
      .gp (w_gp),
      .gg (w_gg)
    );

    // Second-level lookahead: the carry across the group boundary comes from
    // group generate/propagate rather than from the group's last bit carry.
    assign w_cy = w_gg | (w_gp & w_ci);

    // Group-level lookahead must reproduce the in-group carry chain exactly.
    assert property (@(posedge clk) disable iff (!rst_n) (w_co == w_cy));

    if (g < NGRP - 1) begin : g_reg
      cla_ctl_t                  r_ctl;
      logic [WIDTH-LO-BLOCK-1:0] r_a;   // input skew: bits of later groups
      logic [WIDTH-LO-BLOCK-1:0] r_b;
      logic [LO+BLOCK-1:0]       r_ps;  // output deskew: bits already resolved

      // Advance this stage's carry, skewed operands and partial sum unless stalled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ctl <= '0;
          r_a   <= '0;
          r_b   <= '0;
          r_ps  <= '0;
        end else if (!w_stall) begin
          r_ctl.valid <= w_vin;
          r_ctl.carry <= w_cy;
          r_a         <= w_a_in[WIDTH-LO-1:BLOCK];
          r_b         <= w_b_in[WIDTH-LO-1:BLOCK];
          r_ps        <= w_ps;
        end
      end
    end else begin : g_out
      // Capture the completed result; it holds while the consumer stalls.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_out_valid <= 1'b0;
          r_sum       <= '0;
          r_cout      <= 1'b0;
        end else if (!w_stall) begin
          r_out_valid <= w_vin;
          r_sum       <= w_ps;
          r_cout      <= w_cy;
        end
      end

`ifdef CLA_OVERFLOW_EN
      // Carry into the MSB is recovered from the MSB sum bit and its propagate.
      logic w_msb_carry;
      assign w_msb_carry = w_s[BLOCK-1] ^ w_a_in[BLOCK-1] ^ w_b_in[BLOCK-1];

      // Signed overflow flag, registered with the same timing as sum/cout.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (!w_stall) begin
          r_ovf <= w_msb_carry ^ w_cy;
        end
      end
`endif
    end
  end

endmodule : cla_adder_pipe
`default_nettype wire

// File: tb/tb_cla_adder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_adder_pipe
//  Description : Directed self-checking bench for cla_adder_pipe
//                (WIDTH=16, BLOCK=4, latency 4). Inputs change 2 time units
//                after the rising edge; outputs are sampled on the falling
//                edge. A result monitor pairs every output handshake with the
//                oldest accepted operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_adder_pipe;

  localparam int WIDTH = 16;
  localparam int BLOCK = 4;
  localparam int NGRP  = 4;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a         = '0;
  logic [WIDTH-1:0] b         = '0;
  logic             cin       = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CLA_OVERFLOW_EN
  logic             ovf;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  int          n_out = 0;
  int          base;
  logic        seen;
  logic [17:0] q[$];     // {ovf, cout, sum} of accepted operations, oldest first
  logic [17:0] mon_e;

  always #5 clk = ~clk;

  cla_adder_pipe #(
    .WIDTH (WIDTH),
    .BLOCK (BLOCK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CLA_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {signed overflow, carry out, sum}
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c);
    logic [16:0] t;
    t = {1'b0, x} + {1'b0, y} + {16'b0, c};
    return {(x[15] == y[15]) && (t[15] != x[15]), t};
  endfunction

  // Scoreboard: record accepted operations, check every delivered result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) q.push_back(model(a, b, cin));
      if (out_valid && out_ready) begin
        n_out++;
        chk("result_expected", {31'b0, q.size() != 0}, 1);
        if (q.size() != 0) begin
          mon_e = q.pop_front();
          chk("mon_sum", {16'b0, sum}, {16'b0, mon_e[15:0]});
          chk("mon_cout", {31'b0, cout}, {31'b0, mon_e[16]});
`ifdef CLA_OVERFLOW_EN
          chk("mon_ovf", {31'b0, ovf}, {31'b0, mon_e[17]});
`endif
        end
      end
    end
  end

  // Present one operation and hold it until accepted (entered/left at posedge+2).
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic acc;
    acc = 1'b0;
    a = x; b = y; cin = c; in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #2;
    end
    chk("send_accept", {31'b0, acc}, 1);
  endtask

  // Single isolated operation: checks exact latency and the result.
  task automatic run_one(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic c, input logic [17:0] exp);
    send(x, y, c);
    in_valid = 1'b0;
    for (int k = 1; k <= NGRP; k++) begin
      @(negedge clk);
      chk({tag, "_valid"}, {31'b0, out_valid}, {31'b0, (k == NGRP)});
    end
    chk({tag, "_sum"}, {16'b0, sum}, {16'b0, exp[15:0]});
    chk({tag, "_cout"}, {31'b0, cout}, {31'b0, exp[16]});
`ifdef CLA_OVERFLOW_EN
    chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, exp[17]});
`endif
    @(posedge clk); #2;
  endtask

  // Wait (bounded) until every accepted operation has been delivered.
  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    @(posedge clk); #2;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_sum", {16'b0, sum}, 0);
    chk("rst_cout", {31'b0, cout}, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    @(posedge clk); #2;

    // Directed single operations ({ovf, cout, sum} hand-computed)
    run_one("add1234", 16'h1234, 16'h4321, 1'b0, {2'b00, 16'h5555});
    run_one("chain1",  16'hFFFF, 16'h0000, 1'b1, {2'b01, 16'h0000});
    run_one("chain2",  16'hFFFF, 16'hFFFF, 1'b1, {2'b01, 16'hFFFF});
    run_one("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, {2'b10, 16'h8000});
    run_one("ovf_neg", 16'h8000, 16'h8000, 1'b0, {2'b11, 16'h0000});

    // Back-to-back stream, one acceptance per cycle
    base = n_out;
    for (int i = 0; i < 32; i++) send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    in_valid = 1'b0;
    drain();
    chk("stream_count", n_out - base, 32);
    chk("stream_drain", q.size(), 0);

    // Backpressure with a full pipe
    out_ready = 1'b0;
    base = n_out;
    send(16'h0F0F, 16'h00F1, 1'b0);
    send(16'h1111, 16'h2222, 1'b1);
    send(16'hAAAA, 16'h5555, 1'b0);
    send(16'h8001, 16'h8001, 1'b0);
    a = 16'h0102; b = 16'h0304; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'b0, in_ready}, 0);
      chk("bp_valid", {31'b0, out_valid}, 1);
      chk("bp_sum", {16'b0, sum}, 32'h1000);
      chk("bp_cout", {31'b0, cout}, 0);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    send(16'h0102, 16'h0304, 1'b1);
    in_valid = 1'b0;
    drain();
    chk("bp_count", n_out - base, 5);

    // Reset with results in flight
    for (int i = 0; i < 4; i++) send(16'($urandom), 16'($urandom), 1'b0);
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'b0, out_valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 0);
    chk("mid_rst_sum", {16'b0, sum}, 0);
    chk("mid_rst_cout", {31'b0, cout}, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no_stale", {31'b0, seen}, 0);
    @(posedge clk); #2;
    run_one("post_rst", 16'h0001, 16'h0001, 1'b0, {2'b00, 16'h0002});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

endmodule : tb_cla_adder_pipe
`default_nettype wire
